video_axis_pack: RTL and testbench



---
 rtl/video_axis_pack.sv | 148 ++++++++++++++
 tb/tb_video_axis_pack.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_axis_pack.sv
// Packs the gated parallel video stream into an AXI4-Stream master with SOF/EOL/EOF framing.
// A FWFT FIFO with a registered output stage absorbs sink back-pressure; overflow drops the frame.
module video_axis_pack #(
    parameter int DATA_WIDTH = 16,
    parameter int PPC        = 4,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int FIFO_DEPTH = 512,
    parameter int TLAST_MODE = 0
) (
    input  logic                          i_video_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_WIDTH-1:0]         i_video_data,
    input  logic                          i_video_vs,
    input  logic                          i_video_de,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          o_frame_drop,
    output logic                          o_frame_short,
    output logic [15:0]                   o_ovf_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int BPL = IMG_WIDTH / PPC;
    localparam int XW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) + 1 : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int MW  = DATA_WIDTH + 3;

    typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;

    state_t          state, state_nxt;
    logic            vs_d0, vs_rise;
    logic [XW-1:0]   x, x_eff;
    logic [YW-1:0]   y, y_eff;
    logic            first_q;
    logic            beat_sof, beat_eol, beat_eof;
    logic            wr_en, drop_evt, short_evt, fifo_full;
    logic [MW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   mem_cnt, level;
    logic            rd_mem, pop;
    logic            out_valid, out_sof, out_eol, out_eof;
    logic [DATA_WIDTH-1:0] out_data;

    assign vs_rise   = i_video_vs & ~vs_d0;
    assign x_eff     = vs_rise ? '0 : x;
    assign y_eff     = vs_rise ? '0 : y;
    assign beat_sof  = vs_rise | first_q;
    assign beat_eol  = (x_eff == XW'(BPL - 1));
    assign beat_eof  = beat_eol && (y_eff == YW'(IMG_HEIGHT - 1));
    // Full uses the registered occupancy only; a same-cycle pop never frees room for the write.
    assign fifo_full = (level == LW'(FIFO_DEPTH));
    assign short_evt = vs_rise && (state == ACCEPT);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        drop_evt  = 1'b0;
        if (vs_rise || state == ACCEPT) begin
            state_nxt = ACCEPT;
            if (i_video_de) begin
                if (fifo_full) begin
                    drop_evt  = 1'b1;
                    state_nxt = DROP;
                end else begin
                    wr_en = 1'b1;
                    if (beat_eof) state_nxt = IDLE;
                end
            end
        end
    end

    assign rd_mem = (mem_cnt != '0) && (!out_valid || m_axis_tready);
    assign pop    = out_valid && m_axis_tready;

    always_ff @(posedge i_video_clk) begin
        if (wr_en) mem[wr_ptr] <= {i_video_data, beat_sof, beat_eol, beat_eof};
    end

    always_ff @(posedge i_video_clk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            vs_d0         <= 1'b0;
            x             <= '0;
            y             <= '0;
            first_q       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_cnt       <= '0;
            level         <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sof       <= 1'b0;
            out_eol       <= 1'b0;
            out_eof       <= 1'b0;
            o_frame_drop  <= 1'b0;
            o_frame_short <= 1'b0;
            o_ovf_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            vs_d0         <= i_video_vs;
            o_frame_drop  <= drop_evt;
            o_frame_short <= short_evt;
            if (drop_evt && o_ovf_cnt != 16'hFFFF) o_ovf_cnt <= o_ovf_cnt + 16'd1;

            if (wr_en) begin
                x       <= beat_eol ? '0 : x_eff + 1'b1;
                y       <= beat_eol ? y_eff + 1'b1 : y_eff;
                first_q <= 1'b0;
            end else if (vs_rise) begin
                x       <= '0;
                y       <= '0;
                first_q <= 1'b1;
            end

            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_mem) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_mem})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (rd_mem) begin
                {out_data, out_sof, out_eol, out_eof} <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tuser  = out_sof;
    assign m_axis_tlast  = (TLAST_MODE == 1) ? out_eof : out_eol;
    assign o_fifo_level  = level;

endmodule

// File: tb/tb_video_axis_pack.sv
// Directed bench: two packers (line-tlast and frame-tlast) share one stimulus and one scoreboard.
module tb_video_axis_pack;
    localparam int DW = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vs = 1'b0, de = 1'b0, tready = 1'b0;
    logic [DW-1:0] data = '0;

    logic [DW-1:0] tdata0, tdata1;
    logic          tvalid0, tvalid1, tuser0, tuser1, tlast0, tlast1;
    logic          drop0, drop1, short0, short1;
    logic [15:0]   ovf0, ovf1;
    logic [LW-1:0] lvl0, lvl1;

    always #5 clk = ~clk;

    video_axis_pack #(.DATA_WIDTH(DW), .PPC(4), .IMG_WIDTH(16), .IMG_HEIGHT(4),
                      .FIFO_DEPTH(16), .TLAST_MODE(0)) u_line (
        .i_video_clk(clk), .i_rst_n(rst_n), .i_video_data(data), .i_video_vs(vs),
        .i_video_de(de), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0),
        .m_axis_tready(tready), .m_axis_tuser(tuser0), .m_axis_tlast(tlast0),
        .o_frame_drop(drop0), .o_frame_short(short0), .o_ovf_cnt(ovf0), .o_fifo_level(lvl0));

    video_axis_pack #(.DATA_WIDTH(DW), .PPC(4), .IMG_WIDTH(16), .IMG_HEIGHT(4),
                      .FIFO_DEPTH(16), .TLAST_MODE(1)) u_frame (
        .i_video_clk(clk), .i_rst_n(rst_n), .i_video_data(data), .i_video_vs(vs),
        .i_video_de(de), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready), .m_axis_tuser(tuser1), .m_axis_tlast(tlast1),
        .o_frame_drop(drop1), .o_frame_short(short1), .o_ovf_cnt(ovf1), .o_fifo_level(lvl1));

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    beat_t sb[$];
    int    total = 0, bad = 0;
    int    drop_seen = 0, short_seen = 0, peak = 0;
    bit    bp_mode = 1'b0, track_peak = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit d, input logic [DW-1:0] dat);
        vs = v; de = d; data = dat;
        if (bp_mode) tready = ~tready;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input bit s, input bit l, input bit f);
        beat_t b;
        b.d = d; b.sof = s; b.eol = l; b.eof = f;
        sb.push_back(b);
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit keep);
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            if (keep) push(base + DW'(i), i == 0, (i % 4) == 3, i == 15);
            step(1'b0, 1'b1, base + DW'(i));
        end
        step(1'b0, 1'b0, '0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step(1'b0, 1'b0, '0);
            n++;
        end
        step(1'b0, 1'b0, '0);
        chk({tag, "_empty"}, sb.size(), 0);
        chk({tag, "_idle"}, tvalid0, 0);
    endtask

    // Output monitor: scoreboard pops on handshake, stall stability, pulse counting.
    initial begin
        beat_t          e;
        bit             stall_prev = 1'b0;
        logic [DW+1:0]  stall_word = '0;
        forever begin
            @(negedge clk);
            if (track_peak && int'(lvl0) > peak) peak = int'(lvl0);
            if (drop0)  drop_seen++;
            if (short0) short_seen++;
            if (stall_prev) begin
                chk("stall_valid", tvalid0, 1);
                chk("stall_word", {tdata0, tuser0, tlast0}, stall_word);
            end
            stall_prev = tvalid0 && !tready && rst_n;
            stall_word = {tdata0, tuser0, tlast0};
            if (tvalid0 && tready) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", tvalid0 & tready, 0);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", tdata0, e.d);
                    chk("tuser", tuser0, e.sof);
                    chk("tlast_line", tlast0, e.eol);
                    chk("tdata_fmode", tdata1, e.d);
                    chk("tlast_frame", tlast1, e.eof);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, s0;
        // Reset values
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("rst_tvalid", tvalid0, 0);
        chk("rst_tdata", tdata0, 0);
        chk("rst_tuser", tuser0, 0);
        chk("rst_tlast", tlast0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_short", short0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_level", lvl0, 0);
        rst_n  = 1'b1;
        tready = 1'b1;

        // Beats before the first vs rise are ignored
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(16'h0050 + i));
        step(1'b0, 1'b0, '0);
        chk("pre_vs_valid", tvalid0, 0);
        chk("pre_vs_level", lvl0, 0);

        // Nominal frame with first-beat latency
        step(1'b1, 1'b0, '0);
        push(16'h0100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0100);
        chk("lat_n1_valid", tvalid0, 0);
        for (int i = 1; i < 16; i++) begin
            push(16'h0100 + DW'(i), 1'b0, (i % 4) == 3, i == 15);
            step(1'b0, 1'b1, 16'h0100 + DW'(i));
            if (i == 1) begin
                chk("lat_n2_valid", tvalid0, 1);
                chk("lat_n2_data", tdata0, 16'h0100);
                chk("lat_n2_tuser", tuser0, 1);
            end
        end
        step(1'b0, 1'b0, '0);
        drain("nominal", 40);

        // Back-pressure: tready toggles each cycle
        bp_mode = 1'b1; track_peak = 1'b1; peak = 0;
        send_frame(16'h0200, 1'b1);
        drain("backpressure", 80);
        bp_mode = 1'b0; track_peak = 1'b0; tready = 1'b1;
        chk("bp_level_peak", peak >= 8, 1);

        // Overflow: frame A fills the FIFO, frame B is dropped, frame C delivered whole
        tready = 1'b0;
        d0 = drop_seen;
        send_frame(16'h0300, 1'b1);
        chk("ovf_full_level", lvl0, 16);
        send_frame(16'h0400, 1'b0);
        chk("ovf_drop_pulses", drop_seen - d0, 1);
        chk("ovf_cnt", ovf0, 1);
        chk("ovf_cnt_fmode", ovf1, 1);
        chk("ovf_level_held", lvl0, 16);
        tready = 1'b1;
        drain("ovf_stored", 60);
        send_frame(16'h0500, 1'b1);
        drain("ovf_next", 40);

        // Short frame, new frame starts on a beat coinciding with vs rise
        s0 = short_seen;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            push(16'h0600 + DW'(i), i == 0, (i % 4) == 3, 1'b0);
            step(1'b0, 1'b1, 16'h0600 + DW'(i));
        end
        push(16'h0700, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0700);
        for (int i = 1; i < 16; i++) begin
            push(16'h0700 + DW'(i), 1'b0, (i % 4) == 3, i == 15);
            step(1'b0, 1'b1, 16'h0700 + DW'(i));
        end
        step(1'b0, 1'b0, '0);
        chk("short_pulses", short_seen - s0, 1);
        drain("short", 40);

        // Reset mid-frame with five beats held
        tready = 1'b0;
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0800 + DW'(i));
        step(1'b0, 1'b0, '0);
        chk("pre_rst_level", lvl0, 5);
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        chk("mid_rst_valid", tvalid0, 0);
        chk("mid_rst_level", lvl0, 0);
        chk("mid_rst_ovf", ovf0, 0);
        tready = 1'b1;
        for (int i = 5; i < 11; i++) step(1'b0, 1'b1, 16'h0800 + DW'(i));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("post_rst_no_out", tvalid0, 0);
        send_frame(16'h0900, 1'b1);
        drain("post_rst", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
